// File: rtl/reg_writeback.sv
// reg_writeback: register-file write initiator for an RV32I core.
// Merges single-cycle ALU results with variable-latency load responses.
// Loads are queued in a small FIFO, and a load scoreboard tells the
// issue stage which registers still wait on a load.
// Optional feature macro: REG_WRITEBACK_BYPASS_EN. When it is defined, a
// load that arrives while the FIFO is empty and the ALU slot is idle is
// written straight through without passing through the FIFO.
//
// Handshake: a load response transfers on a rising clk edge where
// ld_valid && ld_ready. ld_ready depends only on rst and the occupancy
// at the start of the cycle, never on ld_valid. The ALU path has no
// backpressure and its results are always consumed.
module reg_writeback #(
   parameter int XLEN     = 32,
   parameter int LQ_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   input  logic [4:0]                alu_rd,
   input  logic [XLEN-1:0]           alu_data,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [4:0]                ld_rd,
   input  logic [XLEN-1:0]           ld_data,
   input  logic                      issue_valid,
   input  logic [4:0]                issue_rd,
   input  logic [4:0]                rs1_addr,
   input  logic [4:0]                rs2_addr,
   output logic                      rs1_busy,
   output logic                      rs2_busy,
   output logic [$clog2(LQ_DEPTH):0] lq_count,
   output logic [4:0]                rd_addr,
   output logic [XLEN-1:0]           rd_data,
   output logic                      reg_write
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } lq_entry_t;

   lq_entry_t       mem_q [LQ_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     busy_q, busy_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] rd_data_q, rd_data_d;
   logic            reg_write_q, reg_write_d;

   logic            accept, bypass, push, pop, lq_empty;
   logic            clr_en;
   logic [4:0]      clr_rd;
   lq_entry_t       head;

   // Handshake, FIFO push/pop decisions and the bypass qualifier.
   always_comb begin
      ld_ready = !rst && (count_q < DEPTH_C);
      accept   = ld_valid && ld_ready;
      lq_empty = (count_q == '0);
`ifdef REG_WRITEBACK_BYPASS_EN
      bypass   = accept && !alu_valid && lq_empty;
`else
      bypass   = 1'b0;
`endif
      push     = accept && !bypass;
      pop      = !alu_valid && !lq_empty;
      head     = mem_q[rd_ptr_q];
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // Writeback arbitration: ALU first, then FIFO head, then bypassed load.
   always_comb begin
      rd_addr_d   = rd_addr_q;
      rd_data_d   = rd_data_q;
      reg_write_d = 1'b0;
      clr_en      = 1'b0;
      clr_rd      = 5'd0;
      if (alu_valid) begin
         rd_addr_d   = alu_rd;
         rd_data_d   = alu_data;
         reg_write_d = (alu_rd != 5'd0);
      end else if (pop) begin
         rd_addr_d   = head.rd;
         rd_data_d   = head.data;
         reg_write_d = (head.rd != 5'd0);
         clr_en      = 1'b1;
         clr_rd      = head.rd;
      end else if (bypass) begin
         rd_addr_d   = ld_rd;
         rd_data_d   = ld_data;
         reg_write_d = (ld_rd != 5'd0);
         clr_en      = 1'b1;
         clr_rd      = ld_rd;
      end
   end

   // Scoreboard next state: clear on emitted load, then set on issue so set wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Control state: pointers, occupancy, scoreboard and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         busy_q      <= '0;
         rd_addr_q   <= 5'd0;
         rd_data_q   <= '0;
         reg_write_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q     <= count_d;
         busy_q      <= busy_d;
         rd_addr_q   <= rd_addr_d;
         rd_data_q   <= rd_data_d;
         reg_write_q <= reg_write_d;
      end
   end

   // FIFO storage; contents are only meaningful below count_q, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{rd: ld_rd, data: ld_data};
      end
   end

   assign rs1_busy  = busy_q[rs1_addr];
   assign rs2_busy  = busy_q[rs2_addr];
   assign lq_count  = count_q;
   assign rd_addr   = rd_addr_q;
   assign rd_data   = rd_data_q;
   assign reg_write = reg_write_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed vectors; every expected register
// file write (cycle, rd, data) is queued by the stimulus and checked by an
// independent monitor on the falling edge.
module tb_reg_writeback;

   localparam int XLEN     = 32;
   localparam int LQ_DEPTH = 4;
   localparam int CW       = 3;
   localparam int EW       = 16 + 5 + XLEN;
`ifdef REG_WRITEBACK_BYPASS_EN
   localparam int LD_LAT = 1;
`else
   localparam int LD_LAT = 2;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic            alu_valid, ld_valid, ld_ready, issue_valid;
   logic [4:0]      alu_rd, ld_rd, issue_rd, rs1_addr, rs2_addr, rd_addr;
   logic [XLEN-1:0] alu_data, ld_data, rd_data;
   logic            rs1_busy, rs2_busy, reg_write;
   logic [CW-1:0]   lq_count;

   reg_writeback #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .lq_count(lq_count),
      .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write)
   );

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic expect_wr(input int at, input logic [4:0] rd, input logic [XLEN-1:0] data);
      logic [15:0] at16;
      at16 = at[15:0];
      exp_q.push_back({at16, rd, data});
   endtask

   // Monitor: every reg_write pops one expected entry; overdue entries are misses.
   always @(negedge clk) begin
      if (reg_write) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: rd=%0d data=0x%0h at cycle %0d, no write expected",
                     rd_addr, rd_data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_cycle", 64'(cyc), 64'(mon_e[EW-1:EW-16]));
            check("wr_rd", 64'(rd_addr), 64'(mon_e[XLEN+4:XLEN]));
            check("wr_data", 64'(rd_data), 64'(mon_e[XLEN-1:0]));
         end
      end
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1:EW-16]) < cyc) begin
         mon_e = exp_q.pop_front();
         n_total++;
         $display("FAIL missed_write: rd=%0d data=0x%0h due cycle %0d, still absent at cycle %0d",
                  mon_e[XLEN+4:XLEN], mon_e[XLEN-1:0], mon_e[EW-1:EW-16], cyc);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] s_rd(input int j);
      return 5'((j % 31) + 1);
   endfunction

   function automatic logic [XLEN-1:0] s_data(input int j);
      return 32'hA5A5_0000 ^ (32'(j) * 32'h0101_0101);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int li;
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;

      // Reset values
      @(negedge clk);
      check("reset_reg_write", 64'(reg_write), 0);
      check("reset_rd_addr", 64'(rd_addr), 0);
      check("reset_rd_data", 64'(rd_data), 0);
      check("reset_lq_count", 64'(lq_count), 0);
      check("reset_ld_ready", 64'(ld_ready), 0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(ld_ready), 1);
      next_cycle();

      // ALU write, then ALU write to x0 (consumed, no write)
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      expect_wr(cyc + 1, 5'd5, 32'hDEAD_BEEF);
      next_cycle();
      alu_rd = 5'd0; alu_data = 32'h5555_5555;
      next_cycle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      next_cycle();
      next_cycle();

      // Scoreboard set by issue, load write-back, scoreboard clear
      issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
      @(negedge clk);
      check("busy_before_issue", 64'(rs1_busy), 0);
      next_cycle();
      issue_valid = 1'b0;
      @(negedge clk);
      check("busy_after_issue", 64'(rs1_busy), 1);
      check("busy_x0", 64'(rs2_busy), 0);
      next_cycle();
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_1234;
      expect_wr(cyc + LD_LAT, 5'd7, 32'h0000_1234);
      @(negedge clk);
      check("ld_ready_idle", 64'(ld_ready), 1);
      check("busy_pending", 64'(rs1_busy), 1);
      next_cycle();
      ld_valid = 1'b0;
      @(negedge clk);
      check("lq_count_one", 64'(lq_count), 64'(LD_LAT - 1));
      check("busy_load_inflight", 64'(rs1_busy), 64'(LD_LAT == 2));
      next_cycle();
      @(negedge clk);
      check("lq_count_drained", 64'(lq_count), 0);
      check("busy_cleared", 64'(rs1_busy), 0);
      next_cycle();

      // Backpressure: ALU busy 6 cycles while 5 loads are offered
      base = cyc;
      for (int i = 0; i < 6; i++) expect_wr(base + i + 1, 5'(10 + i), 32'hA000_0000 + 32'(i));
      for (int j = 0; j < 5; j++) expect_wr(base + 7 + j, 5'(20 + j), 32'hC0DE_0000 + 32'(j));
      li = 0;
      for (int i = 0; i < 12; i++) begin
         alu_valid = (i < 6); alu_rd = 5'(10 + i); alu_data = 32'hA000_0000 + 32'(i);
         ld_valid = (li < 5); ld_rd = 5'(20 + li); ld_data = 32'hC0DE_0000 + 32'(li);
         @(negedge clk);
         if (i == 4) begin
            check("full_count", 64'(lq_count), 4);
            check("full_not_ready", 64'(ld_ready), 0);
         end
         if (i == 6) check("pop_opens_no_slot", 64'(ld_ready), 0);
         if (i == 7) check("ready_after_pop", 64'(ld_ready), 1);
         if (ld_valid && ld_ready) li++;
         next_cycle();
      end
      check("loads_accepted", 64'(li), 5);
      alu_valid = 1'b0; ld_valid = 1'b0;
      next_cycle();

      // Issue set and pop clear of the same register in one cycle
      rs1_addr = 5'd3; issue_valid = 1'b1; issue_rd = 5'd3;
      next_cycle();
      ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h0000_0033;
      issue_valid = (LD_LAT == 1);
      expect_wr(cyc + LD_LAT, 5'd3, 32'h0000_0033);
      next_cycle();
      ld_valid = 1'b0; issue_valid = (LD_LAT == 2);
      next_cycle();
      issue_valid = 1'b0;
      @(negedge clk);
      check("set_wins_over_clear", 64'(rs1_busy), 1);
      next_cycle();

      // Reset with three loads queued and a pending scoreboard bit
      base = cyc; rs1_addr = 5'd3; rs2_addr = 5'd9;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(11 + i); alu_data = 32'hB000_0000 + 32'(i);
         ld_valid = 1'b1; ld_rd = 5'(8 + i); ld_data = 32'h8800_0000 + 32'(i);
         issue_valid = (i == 0); issue_rd = 5'd9;
         expect_wr(base + i + 1, 5'(11 + i), 32'hB000_0000 + 32'(i));
         next_cycle();
      end
      alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("pre_reset_count", 64'(lq_count), 3);
      check("pre_reset_busy", 64'(rs2_busy), 1);
      check("ready_in_reset", 64'(ld_ready), 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_count", 64'(lq_count), 0);
      check("post_reset_reg_write", 64'(reg_write), 0);
      check("post_reset_busy1", 64'(rs1_busy), 0);
      check("post_reset_busy2", 64'(rs2_busy), 0);
      check("post_reset_ready", 64'(ld_ready), 1);
      repeat (6) next_cycle();

      // Streaming push+pop every cycle across pointer wrap
      base = cyc;
      expect_wr(base + 1, 5'd1, 32'h0000_000A);
      for (int j = 0; j <= 20; j++) expect_wr(base + 2 + j, s_rd(j), s_data(j));
      for (int i = 0; i <= 21; i++) begin
         alu_valid = (i == 0); alu_rd = 5'd1; alu_data = 32'h0000_000A;
         ld_valid = (i <= 20); ld_rd = s_rd(i); ld_data = s_data(i);
         @(negedge clk);
         if (i >= 1 && i <= 20) check("stream_count", 64'(lq_count), 1);
         next_cycle();
      end
      alu_valid = 1'b0; ld_valid = 1'b0;
      repeat (4) next_cycle();
      @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
